sr_flag_scheduler: RTL and testbench

- Shares one bank of NFLAGS SR flip-flops among NREQ requesters.
- Each requester issues set/reset/hold commands through a valid/ready handshake. A round-robin arbiter grants at most one command per cycle.
- The granted command is converted into a one-cycle s/r pulse to the addressed flop. Illegal commands (s=r=1, or an out-of-range index) are blocked and never reach the flops.
- A sweep FSM resets every flag in sequence on request.

---
 rtl/sr_flag_if.sv | 32 +++
 rtl/sr_flag_scheduler.sv | 152 +++++++++++++++
 tb/tb_sr_flag_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_flag_if.sv
// Requester, sweep and flop-bank signals of the SR flag scheduler.
// The slave modport is the scheduler's view; master is the requester/bank side.
interface sr_flag_if #(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8,
    parameter int IDXW   = 3
);
    localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_s;
    logic [NREQ-1:0]      req_r;
    logic [NREQ*IDXW-1:0] req_idx;
    logic                 sweep_req;
    logic                 sweep_busy;
    logic [NFLAGS-1:0]    ff_s;
    logic [NFLAGS-1:0]    ff_r;
    logic [NFLAGS-1:0]    flag_state;
    logic                 err_illegal;
    logic [SRCW-1:0]      err_src;

    modport master (
        output req_valid, req_s, req_r, req_idx, sweep_req,
        input  req_ready, sweep_busy, ff_s, ff_r, flag_state, err_illegal, err_src
    );

    modport slave (
        input  req_valid, req_s, req_r, req_idx, sweep_req,
        output req_ready, sweep_busy, ff_s, ff_r, flag_state, err_illegal, err_src
    );
endinterface

// File: rtl/sr_flag_scheduler.sv
// Round-robin scheduler turning requester set/reset commands into one-cycle pulses
// for a shared SR flop bank, plus a sequential reset sweep of the whole bank.
module sr_flag_scheduler #(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8,
    parameter int IDXW   = 3
) (
    input  logic     clk,
    input  logic     clear,
    sr_flag_if.slave bus
);
    localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDXW:0]   NFLAGS_W = (IDXW+1)'(NFLAGS);
    localparam logic [SRCW:0]   NREQ_W   = (SRCW+1)'(NREQ);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NFLAGS - 1);
    localparam logic [SRCW-1:0] LAST_REQ = SRCW'(NREQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t            state_r;
    logic [SRCW-1:0]   ptr_r;
    logic [IDXW-1:0]   cnt_r;
    logic [NFLAGS-1:0] ff_s_r;
    logic [NFLAGS-1:0] ff_r_r;
    logic [NFLAGS-1:0] flag_state_r;
    logic              sweep_busy_r;
    logic              err_illegal_r;
    logic [SRCW-1:0]   err_src_r;

    logic [SRCW:0]     cand_s;
    logic              grant_found_s;
    logic [SRCW-1:0]   grant_src_s;
    logic [SRCW-1:0]   next_ptr_s;
    logic              grant_en_s;
    logic [NREQ-1:0]   ready_s;
    logic              cmd_s_s;
    logic              cmd_r_s;
    logic [IDXW-1:0]   cmd_idx_s;
    logic              cmd_illegal_s;
    logic [NFLAGS-1:0] idx_onehot_s;
    logic [NFLAGS-1:0] cnt_onehot_s;

    function automatic logic [NFLAGS-1:0] decode_onehot(input logic [IDXW-1:0] idx);
        logic [NFLAGS-1:0] vec;
        vec = '0;
        for (int f = 0; f < NFLAGS; f++) begin
            vec[f] = (idx == IDXW'(f));
        end
        return vec;
    endfunction

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_src_s   = '0;
        cand_s        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = {1'b0, ptr_r} + (SRCW+1)'(i);
            cand_s = (cand_s >= NREQ_W) ? (cand_s - NREQ_W) : cand_s;
            if (!grant_found_s && bus.req_valid[cand_s[SRCW-1:0]]) begin
                grant_found_s = 1'b1;
                grant_src_s   = cand_s[SRCW-1:0];
            end else begin
                grant_found_s = grant_found_s;
                grant_src_s   = grant_src_s;
            end
        end
    end

    // Grant qualification and decode of the granted command.
    always_comb begin
        grant_en_s    = (state_r == ST_IDLE) && !clear && !bus.sweep_req && grant_found_s;
        ready_s       = grant_en_s ? (NREQ'(1) << grant_src_s) : '0;
        next_ptr_s    = (grant_src_s == LAST_REQ) ? '0 : (grant_src_s + SRCW'(1));
        cmd_s_s       = bus.req_s[grant_src_s];
        cmd_r_s       = bus.req_r[grant_src_s];
        cmd_idx_s     = bus.req_idx[grant_src_s*IDXW +: IDXW];
        // Out-of-range indices are illegal whatever the s/r bits say.
        cmd_illegal_s = (cmd_s_s && cmd_r_s) || ({1'b0, cmd_idx_s} >= NFLAGS_W);
        idx_onehot_s  = decode_onehot(cmd_idx_s);
        cnt_onehot_s  = decode_onehot(cnt_r);
    end

    // Control FSM, pulse registers, shadow flag state and error capture.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r       <= ST_IDLE;
            ptr_r         <= '0;
            cnt_r         <= '0;
            ff_s_r        <= '0;
            ff_r_r        <= '0;
            flag_state_r  <= '0;
            sweep_busy_r  <= 1'b0;
            err_illegal_r <= 1'b0;
            err_src_r     <= '0;
        end else begin
            ff_s_r <= '0;
            ff_r_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.sweep_req) begin
                        state_r      <= ST_SWEEP;
                        cnt_r        <= '0;
                        sweep_busy_r <= 1'b1;
                    end else if (grant_en_s) begin
                        ptr_r <= next_ptr_s;
                        if (cmd_illegal_s) begin
                            err_illegal_r <= 1'b1;
                            err_src_r     <= err_illegal_r ? err_src_r : grant_src_s;
                        end else if (cmd_s_s && !cmd_r_s) begin
                            ff_s_r       <= idx_onehot_s;
                            flag_state_r <= flag_state_r | idx_onehot_s;
                        end else if (cmd_r_s && !cmd_s_s) begin
                            ff_r_r       <= idx_onehot_s;
                            flag_state_r <= flag_state_r & ~idx_onehot_s;
                        end else begin
                            flag_state_r <= flag_state_r;
                        end
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                ST_SWEEP: begin
                    ff_r_r       <= cnt_onehot_s;
                    flag_state_r <= flag_state_r & ~cnt_onehot_s;
                    cnt_r        <= cnt_r + IDXW'(1);
                    if (cnt_r == LAST_IDX) begin
                        state_r      <= ST_IDLE;
                        sweep_busy_r <= 1'b0;
                    end else begin
                        state_r <= ST_SWEEP;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    sweep_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = ready_s;
    assign bus.sweep_busy  = sweep_busy_r;
    assign bus.ff_s        = ff_s_r;
    assign bus.ff_r        = ff_r_r;
    assign bus.flag_state  = flag_state_r;
    assign bus.err_illegal = err_illegal_r;
    assign bus.err_src     = err_src_r;
endmodule

// File: tb/tb_sr_flag_scheduler.sv
// Bench for sr_flag_scheduler: directed scenarios plus random traffic, all
// compared every cycle against a behavioural model of the scheduler's rules.
module tb_sr_flag_scheduler;
    localparam int NREQ   = 4;
    localparam int NFLAGS = 8;
    localparam int IDXW   = 4;

    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;

    sr_flag_if #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW)) bus ();

    sr_flag_scheduler #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit              m_valid = 1'b0;
    int              m_ptr, m_cnt, m_src;
    bit              m_sweep, m_err;
    bit [NFLAGS-1:0] m_flags, m_ffs, m_ffr;

    // Values observed at the most recent negedge
    logic [NREQ-1:0]   obs_ready, exp_rdy;
    logic [NFLAGS-1:0] obs_ffs, obs_ffr, obs_flags;
    logic              obs_busy, obs_err;
    logic [1:0]        obs_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner();
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (m_ptr + i) % NREQ;
            if (bus.req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] v;
        int w;
        v = '0;
        w = winner();
        if (!clear && !m_sweep && !bus.sweep_req && w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    task automatic model_edge();
        int w, idx;
        bit s, r;
        if (clear) begin
            m_valid = 1'b1; m_ptr = 0; m_cnt = 0; m_src = 0;
            m_sweep = 1'b0; m_err = 1'b0; m_flags = '0; m_ffs = '0; m_ffr = '0;
        end else begin
            m_ffs = '0;
            m_ffr = '0;
            if (m_sweep) begin
                m_ffr[m_cnt]   = 1'b1;
                m_flags[m_cnt] = 1'b0;
                m_cnt++;
                if (m_cnt == NFLAGS) m_sweep = 1'b0;
            end else if (bus.sweep_req) begin
                m_sweep = 1'b1;
                m_cnt   = 0;
            end else begin
                w = winner();
                if (w >= 0) begin
                    m_ptr = (w + 1) % NREQ;
                    s   = bus.req_s[w];
                    r   = bus.req_r[w];
                    idx = int'(bus.req_idx[w*IDXW +: IDXW]);
                    if ((s && r) || idx >= NFLAGS) begin
                        if (!m_err) m_src = w;
                        m_err = 1'b1;
                    end else if (s) begin
                        m_ffs[idx] = 1'b1; m_flags[idx] = 1'b1;
                    end else if (r) begin
                        m_ffr[idx] = 1'b1; m_flags[idx] = 1'b0;
                    end
                end
            end
        end
    endtask

    // One clock: compare everything at negedge, then advance the model on posedge.
    task automatic cycle();
        @(negedge clk);
        obs_ready = bus.req_ready;  obs_ffs = bus.ff_s;     obs_ffr = bus.ff_r;
        obs_flags = bus.flag_state; obs_busy = bus.sweep_busy;
        obs_err   = bus.err_illegal; obs_src = bus.err_src;
        exp_rdy   = model_ready();
        if (m_valid) begin
            chk("ready", 32'(obs_ready), 32'(exp_rdy));
            chk("ff_s", 32'(obs_ffs), 32'(m_ffs));
            chk("ff_r", 32'(obs_ffr), 32'(m_ffr));
            chk("flag_state", 32'(obs_flags), 32'(m_flags));
            chk("sweep_busy", 32'(obs_busy), 32'(m_sweep));
            chk("err_illegal", 32'(obs_err), 32'(m_err));
            chk("err_src", 32'(obs_src), 32'(m_src));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_all();
        bus.req_valid = '0; bus.req_s = '0; bus.req_r = '0; bus.req_idx = '0;
        bus.sweep_req = 1'b0;
    endtask

    task automatic set_cmd(input int k, input bit v, input bit s, input bit r, input int idx);
        bus.req_valid[k] = v;
        bus.req_s[k]     = s;
        bus.req_r[k]     = r;
        bus.req_idx[k*IDXW +: IDXW] = IDXW'(idx);
    endtask

    task automatic do_reset();
        clear = 1'b1;
        idle_all();
        cycle();
        cycle();
        clear = 1'b0;
    endtask

    logic [NFLAGS-1:0] walk [12];
    logic              busyv [12];
    int                grant_at, busy_cnt, last_busy;

    initial begin
        clear = 1'b1;
        idle_all();
        do_reset();

        // Reset state
        cycle();
        chk("rst_ready", 32'(obs_ready), 32'h0);
        chk("rst_flags", 32'(obs_flags), 32'h0);
        chk("rst_err", 32'(obs_err), 32'h0);
        chk("rst_busy", 32'(obs_busy), 32'h0);

        // Test 1: requester 2 sets flag 5
        set_cmd(2, 1'b1, 1'b1, 1'b0, 5);
        cycle();
        chk("t1_ready", 32'(obs_ready), 32'h4);
        idle_all();
        cycle();
        chk("t1_ff_s", 32'(obs_ffs), 32'h20);
        chk("t1_ff_r", 32'(obs_ffr), 32'h0);
        chk("t1_flags", 32'(obs_flags), 32'h20);
        cycle();
        chk("t1_ff_s_gone", 32'(obs_ffs), 32'h0);

        // Test 2: everyone valid with hold commands, pointer back at 0
        do_reset();
        for (int k = 0; k < NREQ; k++) set_cmd(k, 1'b1, 1'b0, 1'b0, k);
        for (int n = 0; n < 8; n++) begin
            cycle();
            chk("t2_order", 32'(obs_ready), 32'(1) << (n % NREQ));
            chk("t2_nopulse", 32'(obs_ffs | obs_ffr), 32'h0);
        end
        idle_all();

        // Test 3: illegal s=r=1 from requester 1, then legal reset from requester 3
        set_cmd(1, 1'b1, 1'b1, 1'b1, 2);
        cycle();
        chk("t3_ready1", 32'(obs_ready), 32'h2);
        idle_all();
        set_cmd(3, 1'b1, 1'b0, 1'b1, 6);
        cycle();
        chk("t3_err", 32'(obs_err), 32'h1);
        chk("t3_src", 32'(obs_src), 32'h1);
        chk("t3_nopulse", 32'(obs_ffs | obs_ffr), 32'h0);
        idle_all();
        cycle();
        chk("t3_ff_r", 32'(obs_ffr), 32'h40);

        // Test 4: set 0,3,7 then sweep with requester 0 waiting
        for (int n = 0; n < 3; n++) begin
            set_cmd(0, 1'b1, 1'b1, 1'b0, (n == 0) ? 0 : ((n == 1) ? 3 : 7));
            cycle();
        end
        set_cmd(0, 1'b1, 1'b0, 1'b0, 0);
        bus.sweep_req = 1'b1;
        cycle();
        chk("t4_flags_before", 32'(obs_flags), 32'h89);
        chk("t4_nogrant", 32'(obs_ready), 32'h0);
        bus.sweep_req = 1'b0;
        grant_at = -1; busy_cnt = 0; last_busy = -1;
        for (int n = 0; n < 12; n++) begin
            cycle();
            walk[n]  = obs_ffr;
            busyv[n] = obs_busy;
            if (obs_busy) begin busy_cnt++; last_busy = n; end
            if (obs_ready[0] && grant_at < 0) begin
                grant_at = n;
                idle_all();
            end
        end
        chk("t4_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("t4_grant_after_busy", 32'(grant_at), 32'(last_busy + 1));
        for (int n = 1; n <= 8; n++) chk("t4_walk", 32'(walk[n]), 32'(1) << (n - 1));
        chk("t4_flags_after", 32'(obs_flags), 32'h0);

        // Test 5: clear in the third sweep cycle
        set_cmd(0, 1'b1, 1'b1, 1'b0, 2);
        cycle();
        idle_all();
        bus.sweep_req = 1'b1;
        cycle();
        bus.sweep_req = 1'b0;
        cycle();
        cycle();
        clear = 1'b1;
        cycle();
        chk("t5_busy_at_clear", 32'(obs_busy), 32'h1);
        clear = 1'b0;
        cycle();
        chk("t5_ff_r", 32'(obs_ffr), 32'h0);
        chk("t5_flags", 32'(obs_flags), 32'h0);
        chk("t5_busy", 32'(obs_busy), 32'h0);
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("t5_no_more_pulses", 32'(obs_ffr), 32'h0);
        end

        // Test 6: out-of-range index from requester 0
        set_cmd(0, 1'b1, 1'b1, 1'b0, 8);
        cycle();
        chk("t6_ready", 32'(obs_ready), 32'h1);
        idle_all();
        cycle();
        chk("t6_nopulse", 32'(obs_ffs | obs_ffr), 32'h0);
        chk("t6_err", 32'(obs_err), 32'h1);
        chk("t6_src", 32'(obs_src), 32'h0);

        // Random traffic; commands stay stable until granted
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!bus.req_valid[k] || exp_rdy[k]) begin
                    set_cmd(k, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), $urandom_range(0, 9));
                end
            end
            bus.sweep_req = ($urandom_range(0, 29) == 0);
            clear         = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
